// File: rtl/aether_seq_pkg.sv
// Shared types, opcode/subcommand constants and helpers for the aether instruction sequencer.
// Command word layout is {instr[3:0], param_1[3:0], param_2[15:0]}.
package aether_seq_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RESP      = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [3:0]  instr;
    logic [3:0]  param_1;
    logic [15:0] param_2;
  } aether_cmd_t;

  // Opcodes
  localparam logic [3:0] NOP = 4'h0;
  localparam logic [3:0] RST = 4'h1;
  localparam logic [3:0] WRR = 4'h2;
  localparam logic [3:0] RDR = 4'h3;
  localparam logic [3:0] LDW = 4'h4;
  localparam logic [3:0] CNV = 4'h5;
  localparam logic [3:0] DNS = 4'h6;
  localparam logic [3:0] LIP = 4'h7;

  // Subcommands carried in param_1
  localparam logic [3:0] RST_PART  = 4'h0;
  localparam logic [3:0] RST_FULL  = 4'h1;
  localparam logic [3:0] LDW_STRT  = 4'h0;
  localparam logic [3:0] LDW_CWGT  = 4'h1;
  localparam logic [3:0] LDW_DWGT  = 4'h2;
  localparam logic [3:0] LDW_MOVE  = 4'h3;
  localparam logic [3:0] LDW_CONT  = 4'h4;
  localparam logic [3:0] REG_VERSN = 4'h0;
  localparam logic [3:0] REG_MEMUP = 4'h1;

  // Commands that keep the engine busy until it pulses done.
  function automatic logic is_long_op(aether_cmd_t c);
    logic r;
    r = 1'b0;
    case (c.instr)
      CNV, DNS, LIP: r = 1'b1;
      LDW:           r = (c.param_1 == LDW_CWGT) || (c.param_1 == LDW_DWGT) ||
                         (c.param_1 == LDW_MOVE);
      default:       r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aether_instruct_sequencer_if.sv
// Host link of the sequencer: command push channel and register-read response channel.
// Signal names are seen from the sequencer side (slave modport).
interface aether_instruct_sequencer_if;
  import aether_seq_pkg::*;

  logic        cmd_valid_i;
  logic        cmd_ready_o;
  aether_cmd_t cmd_data_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [15:0] rsp_data_o;

  modport slave (
    input  cmd_valid_i, cmd_data_i, rsp_ready_i,
    output cmd_ready_o, rsp_valid_o, rsp_data_o
  );

  modport master (
    output cmd_valid_i, cmd_data_i, rsp_ready_i,
    input  cmd_ready_o, rsp_valid_o, rsp_data_o
  );
endinterface

// File: rtl/aether_cmd_fifo.sv
// Synchronous command FIFO with push/pop/flush; DEPTH must be a power of two.
// Storage is an unreset array so it can map to distributed/block RAM.
module aether_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  // A push coinciding with a flush survives the flush.
  always_comb begin
    count_d = count_q;
    if (flush_i) count_d = CNT_W'(push_i);
    else         count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (flush_i)    rd_ptr_q <= wr_ptr_q;
      else if (pop_i) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
endmodule

// File: rtl/aether_instruct_sequencer.sv
// Command sequencer between host link and instruction decoder: buffers commands,
// issues single-cycle pulses, stalls on long ops. Optional watchdog: AETHER_SEQ_TIMEOUT_EN.
module aether_instruct_sequencer
  import aether_seq_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  aether_instruct_sequencer_if.slave  host,
  output logic [3:0]                  instruction_o,
  output logic [3:0]                  param_1_o,
  output logic [15:0]                 param_2_o,
  input  logic [15:0]                 dec_data_i,
  input  logic                        eng_done_i,
  output logic                        busy_o,
  output logic                        err_timeout_o
);
  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_WAIT  = WAIT_DONE;
  localparam logic [1:0] ST_RESP  = RESP;

  logic [1:0]  state_q, state_d;
  aether_cmd_t cmd_q;
  logic [15:0] rsp_data_q;
  logic        fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;
  logic [23:0] fifo_rdata;
  logic        timeout_hit;

  assign host.cmd_ready_o = rst_n_i && !fifo_full;
  assign fifo_push        = host.cmd_valid_i && host.cmd_ready_o;

  aether_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(aether_cmd_t))) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (fifo_push),
    .data_i  (host.cmd_data_i),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    case (state_q)
      ST_IDLE: if (!fifo_empty) begin
        fifo_pop = 1'b1;
        state_d  = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (cmd_q.instr == RDR)  state_d = ST_RESP;
        else if (is_long_op(cmd_q)) state_d = ST_WAIT;
        else                     state_d = ST_IDLE;
        fifo_flush = (cmd_q.instr == RST) && (cmd_q.param_1 == RST_FULL);
      end
      ST_WAIT: if (eng_done_i || timeout_hit) state_d = ST_IDLE;
      ST_RESP: if (host.rsp_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (fifo_pop) cmd_q <= aether_cmd_t'(fifo_rdata);
      if (state_q == ST_ISSUE && cmd_q.instr == RDR) rsp_data_q <= dec_data_i;
    end
  end

`ifdef AETHER_SEQ_TIMEOUT_EN
  logic [15:0] wd_cnt_q;
  logic        err_q;

  // Done in the same cycle as expiry takes priority, so no error is raised.
  assign timeout_hit = (state_q == ST_WAIT) && !eng_done_i &&
                       (wd_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == ST_ISSUE)     wd_cnt_q <= '0;
      else if (state_q == ST_WAIT) wd_cnt_q <= wd_cnt_q + 16'd1;
      if (timeout_hit) err_q <= 1'b1;
    end
  end

  assign err_timeout_o = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
  assign err_timeout_o  = 1'b0;
`endif

  assign instruction_o    = (state_q == ST_ISSUE) ? cmd_q.instr   : NOP;
  assign param_1_o        = (state_q == ST_ISSUE) ? cmd_q.param_1 : 4'h0;
  assign param_2_o        = (state_q == ST_ISSUE) ? cmd_q.param_2 : 16'h0;
  assign host.rsp_valid_o = (state_q == ST_RESP);
  assign host.rsp_data_o  = rsp_data_q;
  assign busy_o           = (state_q != ST_IDLE) || !fifo_empty;
endmodule

// File: tb/tb_aether_instruct_sequencer.sv
// Scoreboard bench for aether_instruct_sequencer: expected issues/responses are queued
// at stimulus time and popped by a monitor when the DUT produces them.
module tb_aether_instruct_sequencer;
  import aether_seq_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  instruction, p1;
  logic [15:0] p2, dec_data;
  logic        eng_done, busy, err;

  aether_instruct_sequencer_if host();

  always #5 clk = ~clk;

  aether_instruct_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .host          (host),
    .instruction_o (instruction),
    .param_1_o     (p1),
    .param_2_o     (p2),
    .dec_data_i    (dec_data),
    .eng_done_i    (eng_done),
    .busy_o        (busy),
    .err_timeout_o (err)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int issue_cnt = 0;
  int last_issue_cyc = 0;
  logic [23:0] exp_issue_q[$];
  logic [15:0] exp_rsp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", tag, got, cyc);
    end
  endtask

  // Monitor: every non-NOP decoder pulse and every response handshake is scored.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && instruction != NOP) begin
        issue_cnt++;
        last_issue_cyc = cyc;
        if (exp_issue_q.size() == 0)
          check("unexpected_issue", {8'h0, instruction, p1, p2}, 32'h0);
        else
          check("issue", {8'h0, instruction, p1, p2}, {8'h0, exp_issue_q.pop_front()});
      end
      if (rst_n && host.rsp_valid_o && host.rsp_ready_i) begin
        if (exp_rsp_q.size() == 0)
          check("unexpected_rsp", {16'h0, host.rsp_data_o}, 32'hFFFF_FFFF);
        else
          check("rsp_data", {16'h0, host.rsp_data_o}, {16'h0, exp_rsp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [23:0] d, input int tries, output bit acc);
    bit r;
    acc = 1'b0;
    @(posedge clk);
    #1;
    host.cmd_valid_i = 1'b1;
    host.cmd_data_i  = d;
    for (int i = 0; i < tries && !acc; i++) begin
      @(negedge clk);
      r = host.cmd_ready_o;
      @(posedge clk);
      acc = r;
    end
    #1;
    host.cmd_valid_i = 1'b0;
  endtask

  task automatic send(input logic [23:0] d, input bit will_issue);
    bit acc;
    push_cmd(d, 20, acc);
    check("accept", {31'h0, acc}, 32'h1);
    if (acc && will_issue) exp_issue_q.push_back(d);
  endtask

  task automatic wait_issues(input string tag, input int target, input int max_cyc);
    for (int i = 0; i < max_cyc && issue_cnt < target; i++) tick();
    check(tag, issue_cnt, target);
  endtask

  task automatic pulse_done(output int pc);
    @(posedge clk);
    #1;
    eng_done = 1'b1;
    pc = cyc;
    @(posedge clk);
    #1;
    eng_done = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int  base, pc;
    bit  acc;
    host.cmd_valid_i = 1'b0;
    host.cmd_data_i  = '0;
    host.rsp_ready_i = 1'b0;
    dec_data = 16'h0;
    eng_done = 1'b0;

    // Reset
    repeat (3) @(posedge clk);
    tick();
    check("rst_ready", {31'h0, host.cmd_ready_o}, 32'h0);
    check("rst_instr", {28'h0, instruction}, {28'h0, NOP});
    check("rst_rsp_valid", {31'h0, host.rsp_valid_o}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", {31'h0, host.cmd_ready_o}, 32'h1);

    // Single WRR: 2-cycle latency, one ISSUE cycle, back to idle
    send({WRR, REG_MEMUP, 16'h1234}, 1'b1);
    tick();
    check("wrr_nop_before", {28'h0, instruction}, {28'h0, NOP});
    check("wrr_busy", {31'h0, busy}, 32'h1);
    tick();
    check("wrr_issue_word", {8'h0, instruction, p1, p2}, {8'h0, WRR, REG_MEMUP, 16'h1234});
    tick();
    check("wrr_nop_after", {28'h0, instruction}, {28'h0, NOP});
    check("wrr_idle_busy", {31'h0, busy}, 32'h0);

    // RDR with a stalled host response channel
    dec_data = 16'hA5A5;
    exp_rsp_q.push_back(16'hA5A5);
    send({RDR, REG_VERSN, 16'h0000}, 1'b1);
    for (int i = 0; i < 10 && !host.rsp_valid_o; i++) tick();
    dec_data = 16'h0000;
    for (int k = 0; k < 5; k++) begin
      check("rsp_hold_valid", {31'h0, host.rsp_valid_o}, 32'h1);
      check("rsp_hold_data", {16'h0, host.rsp_data_o}, 32'hA5A5);
      tick();
    end
    @(posedge clk);
    #1;
    host.rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    host.rsp_ready_i = 1'b0;
    tick();
    check("rsp_cleared", {31'h0, host.rsp_valid_o}, 32'h0);

    // CNV stalls the following WRR until done
    base = issue_cnt;
    send({CNV, 4'h3, 16'h0040}, 1'b1);
    send({WRR, REG_MEMUP, 16'h00BE}, 1'b1);
    wait_issues("cnv_issued", base + 1, 10);
    repeat (10) tick();
    check("wrr_stalled", issue_cnt, base + 1);
    check("stall_busy", {31'h0, busy}, 32'h1);
    pulse_done(pc);
    wait_issues("wrr_after_done", base + 2, 10);
    check("done_to_issue", last_issue_cyc - pc, 2);

    // Fill the FIFO behind a long op
    base = issue_cnt;
    send({CNV, 4'h0, 16'h0001}, 1'b1);
    wait_issues("fill_cnv_issued", base + 1, 10);
    for (int i = 0; i < DEPTH; i++) send({WRR, 4'(i), 16'(16'h1000 + i)}, 1'b1);
    tick();
    check("full_ready_low", {31'h0, host.cmd_ready_o}, 32'h0);
    push_cmd({WRR, 4'hF, 16'hDEAD}, 3, acc);
    check("fifth_rejected", {31'h0, acc}, 32'h0);
    pulse_done(pc);
    for (int i = 0; i < 5 && !host.cmd_ready_o; i++) tick();
    check("ready_after_pop", {31'h0, host.cmd_ready_o}, 32'h1);
    wait_issues("fill_drain", base + 1 + DEPTH, 40);

    // RST_FULL flushes queued commands
    base = issue_cnt;
    send({CNV, 4'h0, 16'h0002}, 1'b1);
    wait_issues("flush_cnv_issued", base + 1, 10);
    send({RST, RST_FULL, 16'h0000}, 1'b1);
    send({WRR, REG_MEMUP, 16'h0AAA}, 1'b0);
    send({WRR, REG_MEMUP, 16'h0BBB}, 1'b0);
    pulse_done(pc);
    wait_issues("rst_issued", base + 2, 10);
    repeat (10) tick();
    check("flush_no_more_issue", issue_cnt, base + 2);
    check("flush_busy", {31'h0, busy}, 32'h0);
    check("flush_ready", {31'h0, host.cmd_ready_o}, 32'h1);

`ifdef AETHER_SEQ_TIMEOUT_EN
    // Watchdog: error after TMO cycles in WAIT_DONE, cleared by reset
    base = issue_cnt;
    send({DNS, 4'h0, 16'h0003}, 1'b1);
    wait_issues("dns_issued", base + 1, 10);
    for (int k = 1; k <= TMO; k++) begin
      tick();
      check("wd_no_err", {31'h0, err}, 32'h0);
    end
    tick();
    check("timeout_err", {31'h0, err}, 32'h1);
    check("timeout_idle", {31'h0, busy}, 32'h0);
    repeat (3) tick();
    check("timeout_sticky", {31'h0, err}, 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("err_cleared", {31'h0, err}, 32'h0);
`else
    // No watchdog: WAIT_DONE holds indefinitely; reset mid-wait recovers
    base = issue_cnt;
    send({DNS, 4'h0, 16'h0003}, 1'b1);
    wait_issues("dns_issued", base + 1, 10);
    repeat (20) tick();
    check("no_timeout_err", {31'h0, err}, 32'h0);
    check("wait_busy", {31'h0, busy}, 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("reset_mid_wait_busy", {31'h0, busy}, 32'h0);
`endif

    base = issue_cnt;
    send({WRR, REG_MEMUP, 16'h5678}, 1'b1);
    wait_issues("post_reset_issue", base + 1, 10);

    repeat (3) tick();
    check("sb_issue_empty", exp_issue_q.size(), 0);
    check("sb_rsp_empty", exp_rsp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
